uart_rx_param: RTL and testbench

//   Parametrised oversampling UART receiver for the full-duplex UART/7-seg design. Runs on
//   clk_50Mhz, gated by a baud-rate tick at OVS x baud.

---
 rtl/uart_rx_param_pkg.sv | 17 +
 rtl/uart_rx_param_sampler.sv | 27 ++
 rtl/uart_rx_param.sv | 119 +++++++++++
 tb/tb_uart_rx_param.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/uart_rx_param_pkg.sv
// uart_rx_param_pkg: receiver state encodings, parity modes and the majority helper.
package uart_rx_param_pkg;
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } state_e;
    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction
endpackage

// File: rtl/uart_rx_param_sampler.sv
// uart_rx_param_sampler: 2-FF rx synchroniser and 3-tap majority vote.
module uart_rx_param_sampler import uart_rx_param_pkg::*; (
    input  logic clk_50Mhz,
    input  logic rst,
    input  logic rx_i,
    input  logic sample_i,
    output logic rxs_o,
    output logic maj_o
);
    logic [1:0] sync_q, sync_d, taps_q, taps_d;
    always_comb begin
        sync_d = {sync_q[0], rx_i};
        taps_d = sample_i ? {taps_q[0], sync_q[1]} : taps_q;
    end
    always_ff @(posedge clk_50Mhz or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
            taps_q <= 2'b00;
        end else begin
            sync_q <= sync_d;
            taps_q <= taps_d;
        end
    end
    // the third vote is the live sample taken on the decision tick itself
    assign rxs_o = sync_q[1];
    assign maj_o = maj3(taps_q[1], taps_q[0], sync_q[1]);
endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampling UART receiver with parity, 1/2 stop bits,
// false-start rejection, break recovery and a valid/ready output stage.
module uart_rx_param import uart_rx_param_pkg::*; #(
    parameter int DBITS  = 8,
    parameter int OVS    = 16,
    parameter int PARITY = 0,
    parameter int SBITS  = 1
) (
    input  logic             clk_50Mhz,
    input  logic             rst,
    input  logic             tick,
    input  logic             rx,
    output logic [DBITS-1:0] data_out,
    output logic             valid,
    input  logic             ready_in,
    output logic             parity_err,
    output logic             frame_err,
    output logic             overrun,
    output logic             busy
);
    localparam int CW = $clog2(OVS);
    localparam int BW = $clog2(DBITS + 1);
    state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] idx_q, idx_d;
    logic [DBITS-1:0] sr_q, sr_d, data_q, data_d;
    logic pe_q, pe_d, fe_q, fe_d;
    logic valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d, ovr_q, ovr_d;
    logic rxs, maj, in_bit, last_cnt, mid_cnt, decide, sample, last_data, last_stop;
    logic fe_now, deliver, hs, load, go_data;
    assign in_bit    = state_q inside {ST_DATA, ST_PARITY, ST_STOP};
    assign last_cnt  = cnt_q == CW'(OVS - 1);
    assign mid_cnt   = cnt_q == CW'(OVS / 2 - 1);
    assign decide    = tick & in_bit & last_cnt;
    assign sample    = tick & in_bit & (cnt_q >= CW'(OVS - 3));
    assign last_data = idx_q == BW'(DBITS - 1);
    assign last_stop = idx_q == BW'(SBITS - 1);
    assign fe_now    = fe_q | ~maj;
    assign go_data   = tick & mid_cnt & (state_q == ST_START) & ~rxs;
    assign hs        = valid_q & ready_in;
    uart_rx_param_sampler u_sampler (
        .clk_50Mhz(clk_50Mhz),
        .rst      (rst),
        .rx_i     (rx),
        .sample_i (sample),
        .rxs_o    (rxs),
        .maj_o    (maj)
    );
    always_ff @(posedge clk_50Mhz or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   state_d = rxs ? ST_IDLE : ST_START;
            ST_START:  if (tick && mid_cnt) state_d = rxs ? ST_IDLE : ST_DATA;
            ST_DATA:   if (decide && last_data) state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            ST_PARITY: if (decide) state_d = ST_STOP;
            ST_STOP:   if (decide && last_stop) state_d = (fe_now && !rxs) ? ST_BREAK : ST_IDLE;
            ST_BREAK:  state_d = rxs ? ST_IDLE : ST_BREAK;
            default:   state_d = ST_IDLE;
        endcase
    end
    always_comb begin
        busy    = state_q != ST_IDLE;
        deliver = decide & (state_q == ST_STOP) & last_stop;
    end
    always_comb begin
        cnt_d = (state_q == ST_IDLE || go_data) ? '0 :
                tick ? (last_cnt ? '0 : cnt_q + CW'(1)) : cnt_q;
        idx_d = (state_q == ST_IDLE || go_data) ? '0 :
                (decide && state_q == ST_DATA) ? (last_data ? '0 : idx_q + BW'(1)) :
                (decide && state_q == ST_STOP) ? (last_stop ? '0 : idx_q + BW'(1)) : idx_q;
        sr_d  = (decide && state_q == ST_DATA) ? {maj, sr_q[DBITS-1:1]} : sr_q;
        pe_d  = go_data ? 1'b0 :
                (decide && state_q == ST_PARITY) ? (^sr_q ^ maj ^ (PARITY == PAR_ODD)) : pe_q;
        fe_d  = go_data ? 1'b0 : (decide && state_q == ST_STOP) ? fe_now : fe_q;
    end
    // a word arriving while one is still held is dropped, not queued
    always_comb begin
        load    = deliver & (~valid_q | hs);
        data_d  = load ? sr_q : data_q;
        perr_d  = load ? pe_q : perr_q;
        ferr_d  = load ? fe_now : ferr_q;
        valid_d = load | (valid_q & ~hs);
        ovr_d   = (deliver & valid_q & ~hs) | (ovr_q & ~hs);
    end
    always_ff @(posedge clk_50Mhz or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            sr_q    <= '0;
            pe_q    <= 1'b0;
            fe_q    <= 1'b0;
            data_q  <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sr_q    <= sr_d;
            pe_q    <= pe_d;
            fe_q    <= fe_d;
            data_q  <= data_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end
    assign data_out   = data_q;
    assign valid      = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed frames into 8N1, 8O1 and 8N2 receivers sharing clock, tick and reset.
module tb_uart_rx_param;
    logic clk_50Mhz = 1'b0;
    logic rst = 1'b1;
    logic tick = 1'b0;
    logic [2:0] rx = 3'b111;
    logic [2:0] rdy = 3'b000;
    logic [7:0] dout [3];
    logic vld [3], perr [3], ferr [3], ovr [3], bsy [3];
    int n_cmp = 0, n_err = 0, hs0 = 0, hs2 = 0;
    logic [7:0] last0 = 8'h00;
    always #10 clk_50Mhz = ~clk_50Mhz;
    initial forever begin
        repeat (3) @(posedge clk_50Mhz);
        #1 tick = 1'b1;
        @(posedge clk_50Mhz);
        #1 tick = 1'b0;
    end
    uart_rx_param #(.PARITY(0), .SBITS(1)) u0 (
        .clk_50Mhz(clk_50Mhz), .rst(rst), .tick(tick), .rx(rx[0]), .data_out(dout[0]),
        .valid(vld[0]), .ready_in(rdy[0]), .parity_err(perr[0]), .frame_err(ferr[0]),
        .overrun(ovr[0]), .busy(bsy[0]));
    uart_rx_param #(.PARITY(1), .SBITS(1)) u1 (
        .clk_50Mhz(clk_50Mhz), .rst(rst), .tick(tick), .rx(rx[1]), .data_out(dout[1]),
        .valid(vld[1]), .ready_in(rdy[1]), .parity_err(perr[1]), .frame_err(ferr[1]),
        .overrun(ovr[1]), .busy(bsy[1]));
    uart_rx_param #(.PARITY(0), .SBITS(2)) u2 (
        .clk_50Mhz(clk_50Mhz), .rst(rst), .tick(tick), .rx(rx[2]), .data_out(dout[2]),
        .valid(vld[2]), .ready_in(rdy[2]), .parity_err(perr[2]), .frame_err(ferr[2]),
        .overrun(ovr[2]), .busy(bsy[2]));
    always @(posedge clk_50Mhz) begin
        if (vld[0] && rdy[0]) begin
            hs0 <= hs0 + 1;
            last0 <= dout[0];
        end
        if (vld[2] && rdy[2]) hs2 <= hs2 + 1;
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic idle(input int n);
        repeat (n) @(negedge clk_50Mhz);
    endtask
    task automatic bit_t(input int u, input logic b, input logic g);
        rx[u] = b;
        if (g) begin
            idle(28);
            rx[u] = ~b;
            idle(4);
            rx[u] = b;
            idle(32);
        end else idle(64);
    endtask
    // start, 8 data LSB first, optional parity, stop(s), then one idle bit
    task automatic send(input int u, input logic [7:0] d, input logic np, input logic p,
                        input logic s2, input int gb);
        bit_t(u, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) bit_t(u, d[i], i == gb);
        if (np) bit_t(u, p, 1'b0);
        bit_t(u, 1'b1, 1'b0);
        if (u == 2) bit_t(u, s2, 1'b0);
        bit_t(u, 1'b1, 1'b0);
    endtask
    task automatic take(input int u);
        @(negedge clk_50Mhz);
        rdy[u] = 1'b1;
        @(negedge clk_50Mhz);
        rdy[u] = 1'b0;
    endtask
    initial begin
        idle(3);
        check("rst_data", dout[0], 0);
        check("rst_valid", vld[0], 0);
        check("rst_flags", {perr[0], ferr[0], ovr[0]}, 0);
        check("rst_busy", bsy[0], 0);
        rst = 1'b0;
        idle(10);
        rdy[0] = 1'b1;
        fork
            send(0, 8'hA5, 1'b0, 1'b0, 1'b1, -1);
            begin idle(300); check("t1_busy_mid", bsy[0], 1); end
        join
        check("t1_words", hs0, 1);
        check("t1_word", last0, 8'hA5);
        check("t1_data", dout[0], 8'hA5);
        check("t1_flags", {perr[0], ferr[0], ovr[0]}, 0);
        check("t1_idle", {bsy[0], vld[0]}, 0);
        send(1, 8'h3C, 1'b1, 1'b0, 1'b1, -1);
        check("t2_valid", vld[1], 1);
        check("t2_data", dout[1], 8'h3C);
        check("t2_perr_bad", perr[1], 1);
        check("t2_ferr", ferr[1], 0);
        take(1);
        check("t2_taken", vld[1], 0);
        send(1, 8'h3C, 1'b1, 1'b1, 1'b1, -1);
        check("t2_perr_ok", perr[1], 0);
        check("t2_valid2", vld[1], 1);
        take(1);
        rx[0] = 1'b0;
        idle(8);
        check("t3_busy_start", bsy[0], 1);
        idle(8);
        rx[0] = 1'b1;
        idle(64);
        check("t3_false_idle", bsy[0], 0);
        check("t3_false_words", hs0, 1);
        send(0, 8'h55, 1'b0, 1'b0, 1'b1, 2);
        check("t3_glitch_words", hs0, 2);
        check("t3_glitch_word", last0, 8'h55);
        rdy[0] = 1'b0;
        send(0, 8'h11, 1'b0, 1'b0, 1'b1, -1);
        send(0, 8'h22, 1'b0, 1'b0, 1'b1, -1);
        check("t4_data", dout[0], 8'h11);
        check("t4_valid", vld[0], 1);
        check("t4_overrun", ovr[0], 1);
        take(0);
        check("t4_clear", {vld[0], ovr[0]}, 0);
        check("t4_hold", dout[0], 8'h11);
        check("t4_words", hs0, 3);
        send(2, 8'h5A, 1'b0, 1'b0, 1'b0, -1);
        check("t5_data", dout[2], 8'h5A);
        check("t5_ferr", ferr[2], 1);
        check("t5_valid", vld[2], 1);
        check("t5_idle", bsy[2], 0);
        take(2);
        rdy[2] = 1'b1;
        rx[2] = 1'b0;
        idle(20 * 64);
        check("t5_brk_words", hs2, 2);
        check("t5_brk_busy", bsy[2], 1);
        check("t5_brk_data", dout[2], 0);
        check("t5_brk_ferr", ferr[2], 1);
        rx[2] = 1'b1;
        idle(8);
        check("t5_brk_exit", bsy[2], 0);
        check("t5_brk_once", hs2, 2);
        rdy[0] = 1'b1;
        fork
            send(0, 8'hF0, 1'b0, 1'b0, 1'b1, -1);
            begin
                idle(3 * 64 + 20);
                rst = 1'b1;
                #1;
                check("t6_rst_data", dout[0], 0);
                check("t6_rst_busy", bsy[0], 0);
                check("t6_rst_ferr2", ferr[2], 0);
            end
        join
        idle(4);
        rst = 1'b0;
        idle(20);
        send(0, 8'h0F, 1'b0, 1'b0, 1'b1, -1);
        check("t6_word", last0, 8'h0F);
        check("t6_data", dout[0], 8'h0F);
        check("t6_flags", {perr[0], ferr[0], ovr[0]}, 0);
        check("t6_words", hs0, 4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
